// File: rtl/seq_det_sched_pkg.sv
// Shared types for the sequence-detector scheduler: FSM state encoding and the
// match length of the external serial detector.
package seq_det_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FLUSH = 3'd1,
    S_SHIFT = 3'd2,
    S_DRAIN = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  localparam int DET_RUN_LEN = 4;

endpackage

// File: rtl/seq_det_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting the search at the pointer, pointer
// advances to winner+1 only on an accepted grant.
module rr_arbiter #(
  parameter int N_REQ = 4,
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  input  logic             accept,
  output logic [N_REQ-1:0] grant,
  output logic [PW-1:0]    winner
);

  logic [PW-1:0] ptr;
  logic          found;
  int            k;

  always_comb begin
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    k      = 0;
    for (int i = 0; i < N_REQ; i++) begin
      k = int'(ptr) + i;
      if (k >= N_REQ) k = k - N_REQ;
      if (en && !found && req[k]) begin
        found    = 1'b1;
        grant[k] = 1'b1;
        winner   = PW'(k);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= (winner == PW'(N_REQ - 1)) ? '0 : winner + 1'b1;
    end
  end

endmodule

// File: rtl/seq_det_sched.sv
// Time-shares one serial 4-ones detector among N_REQ requesters: flush, shift the
// word LSB first, count hits, and return {id, hits} on a valid/ready port.
module seq_det_sched
  import seq_det_sched_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int WORD_W = 8,
  parameter int CNT_W  = 4,
  parameter int ID_W   = $clog2(N_REQ)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [N_REQ-1:0]        i_req_valid,
  input  logic [N_REQ*WORD_W-1:0] i_req_data,
  output logic [N_REQ-1:0]        o_req_ready,
  output logic                    o_x,
  input  logic                    i_y,
  output logic                    o_rsp_valid,
  input  logic                    i_rsp_ready,
  output logic [ID_W-1:0]         o_rsp_id,
  output logic [CNT_W-1:0]        o_rsp_hits,
  output logic                    o_busy
);

  localparam int IDX_W = $clog2(WORD_W);

  state_t             state, state_nxt;
  logic [WORD_W-1:0]  word;
  logic [IDX_W-1:0]   idx;
  logic [CNT_W-1:0]   hits;
  logic [ID_W-1:0]    id;
  logic [ID_W-1:0]    winner;
  logic [N_REQ-1:0]   grant;
  logic               idle, accept, last_bit, sample;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  assign idle = (state == S_IDLE);

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .en     (idle),
    .req    (i_req_valid),
    .accept (accept),
    .grant  (grant),
    .winner (winner)
  );

  assign accept   = |(i_req_valid & grant);
  assign last_bit = (idx == IDX_W'(WORD_W - 1));
  // The detector output is one cycle late, so SHIFT idx=0 still sees the flush bit.
  assign sample   = ((state == S_SHIFT) && (idx != '0)) || (state == S_DRAIN);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_FLUSH;
      S_FLUSH: state_nxt = S_SHIFT;
      S_SHIFT: if (last_bit) state_nxt = S_DRAIN;
      S_DRAIN: state_nxt = S_RESP;
      S_RESP:  if (i_rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= S_IDLE;
      idx   <= '0;
      hits  <= '0;
      id    <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        idx  <= '0;
        hits <= '0;
        id   <= winner;
      end else begin
        if (state == S_SHIFT) idx <= idx + 1'b1;
        if (sample && i_y) hits <= sat_inc(hits);
      end
    end
  end

  // Word register is pure datapath: loaded on accept, shifted right during SHIFT.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      word <= i_req_data[int'(winner)*WORD_W +: WORD_W];
    end else if (state == S_SHIFT) begin
      word <= word >> 1;
    end
  end

  assign o_req_ready = grant;
  assign o_x         = (state == S_SHIFT) && word[0];
  assign o_rsp_valid = (state == S_RESP);
  assign o_rsp_id    = id;
  assign o_rsp_hits  = hits;
  assign o_busy      = !idle;

endmodule
